gpio_bus_arbiter: RTL

- Two-master, single-slave arbiter for the GPIO register port (wea/addr/din/dout).
- Lets the CPU-side bridge (master 0) and the vision/DMA engine (master 1) share one GPIO instance without collisions.
- Round-robin grant with a fixed 3-cycle transaction (IDLE -> ISSUE -> RESP) and a single-cycle ack pulse per transaction.
- Sits between the masters and the GPIO block, in the same clock domain.

---
 rtl/gpio_bus_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter in front of the single GPIO register port.
// Each grant runs a fixed IDLE -> ISSUE -> RESP sequence and ends in a one-cycle ack pulse.
module gpio_bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_din,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_din,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_dout,
  output logic              s_wea,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s_dout,
  output logic [1:0]        dbg_state
);

  // Handshake: a master raises req with we/addr/din and holds them until its ack
  // pulse; req is only sampled in IDLE, so anything after the grant edge is ignored.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                rr_ptr;
  logic                gnt_id;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_din;
  logic                grant_valid;
  logic                grant_sel;

  // rr_ptr only breaks ties; a lone requester always wins.
  always_comb begin
    grant_valid = m0_req | m1_req;
    grant_sel   = (m0_req & m1_req) ? rr_ptr : m1_req;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_valid) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Slave port is combinational from state so an async reset drops it at once.
  always_comb begin
    s_wea  = 1'b0;
    s_addr = '0;
    s_din  = '0;
    if (state == ISSUE) begin
      s_wea  = lat_we;
      s_addr = lat_addr;
      s_din  = lat_din;
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      gnt_id   <= 1'b0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_dout  <= '0;
      m1_dout  <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        gnt_id   <= grant_sel;
        lat_we   <= grant_sel ? m1_we   : m0_we;
        lat_addr <= grant_sel ? m1_addr : m0_addr;
        lat_din  <= grant_sel ? m1_din  : m0_din;
      end
      m0_ack <= (state == ISSUE) && (gnt_id == 1'b0);
      m1_ack <= (state == ISSUE) && (gnt_id == 1'b1);
      // Read data is the register value before this cycle's write lands.
      if (state == ISSUE) begin
        if (gnt_id) m1_dout <= s_dout;
        else        m0_dout <= s_dout;
      end
      if (state == RESP) rr_ptr <= ~gnt_id;
    end
  end

endmodule
